// File: rtl/pair_swap.sv
// Compare-exchange cell: presents the two operands in ascending unsigned order.
// Equal operands pass through untouched so the sort built on it stays stable.
module pair_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val
);

  always_comb begin
    if (b < a) begin
      min_val = b;
      max_val = a;
    end else begin
      min_val = a;
      max_val = b;
    end
  end

endmodule

// File: rtl/pair_sort_seq.sv
// Buffers DIM words, bubble-sorts them in place through one shared pair_swap
// with early exit, then streams them out in ascending unsigned order.
module pair_sort_seq #(
  parameter int DIM   = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int IDXW = (DIM > 1) ? $clog2(DIM) : 1;

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] SORT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [IDXW-1:0] LAST = IDXW'(DIM - 1);
  localparam logic [IDXW-1:0] ONE  = IDXW'(1);

  logic [1:0]      state, state_nxt;
  logic [IDXW-1:0] wr_idx, wr_nxt;
  logic [IDXW-1:0] rd_idx, rd_nxt;
  logic [IDXW-1:0] j, j_nxt;
  logic [IDXW-1:0] limit, limit_nxt;
  logic            swapped, swapped_nxt;

  logic [WIDTH-1:0] mem [DIM];

  logic [WIDTH-1:0] op_a, op_b, sw_min, sw_max;
  logic             swap_now;
  logic             load_we, sort_we;

  // Operand and read-port muxes; j+1 wraps only outside SORT, where it is unused.
  always_comb begin
    op_a     = '0;
    op_b     = '0;
    out_data = '0;
    for (int k = 0; k < DIM; k++) begin
      if (IDXW'(k) == j)          op_a     = mem[k];
      if (IDXW'(k) == j + ONE)    op_b     = mem[k];
      if (IDXW'(k) == rd_idx)     out_data = mem[k];
    end
  end

  pair_swap #(.WIDTH(WIDTH)) u_swap (
    .a       (op_a),
    .b       (op_b),
    .min_val (sw_min),
    .max_val (sw_max)
  );

  assign swap_now = (sw_min != op_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      wr_idx  <= '0;
      rd_idx  <= '0;
      j       <= '0;
      limit   <= '0;
      swapped <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_idx  <= wr_nxt;
      rd_idx  <= rd_nxt;
      j       <= j_nxt;
      limit   <= limit_nxt;
      swapped <= swapped_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wr_nxt      = wr_idx;
    rd_nxt      = rd_idx;
    j_nxt       = j;
    limit_nxt   = limit;
    swapped_nxt = swapped;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    load_we     = 1'b0;
    sort_we     = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_we = 1'b1;
          if (wr_idx == LAST) begin
            state_nxt   = (DIM == 1) ? DRAIN : SORT;
            j_nxt       = '0;
            limit_nxt   = LAST;
            swapped_nxt = 1'b0;
          end else begin
            wr_nxt = wr_idx + ONE;
          end
        end
      end
      SORT: begin
        busy    = 1'b1;
        sort_we = 1'b1;
        // A pass that made no exchange, including this last compare, proves the array sorted.
        if (j == limit - ONE) begin
          if (!(swapped | swap_now) || limit == ONE) begin
            state_nxt = DRAIN;
          end else begin
            limit_nxt   = limit - ONE;
            j_nxt       = '0;
            swapped_nxt = 1'b0;
          end
        end else begin
          j_nxt       = j + ONE;
          swapped_nxt = swapped | swap_now;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (rd_idx == LAST) begin
            state_nxt = LOAD;
            wr_nxt    = '0;
            rd_nxt    = '0;
          end else begin
            rd_nxt = rd_idx + ONE;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DIM; k++) mem[k] <= '0;
    end else begin
      for (int k = 0; k < DIM; k++) begin
        if (load_we && IDXW'(k) == wr_idx)       mem[k] <= in_data;
        else if (sort_we && IDXW'(k) == j)       mem[k] <= sw_min;
        else if (sort_we && IDXW'(k) == j + ONE) mem[k] <= sw_max;
      end
    end
  end

endmodule

// File: tb/tb_pair_sort_seq.sv
// Bench for pair_sort_seq: an abstract batch model drives a per-cycle compare
// process; directed tests pin the model with hand-computed streams and latencies.
module tb_pair_sort_seq;

  localparam int DIM   = 4;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  pair_sort_seq #(.DIM(DIM), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model state: collecting words, then a known sort duration, then a sorted queue.
  int unsigned pend[$];
  int unsigned exp_q[$];
  int          sort_left = 0;
  bit          collecting = 1'b1;
  int          obs_q[$];
  int          busy_seen = 0;
  int          last_out_cyc = 0;
  int          first_acc_cyc = 0;
  bit          stall_prev = 1'b0;
  int          held = 0;

  function automatic int bubble_cycles(input int unsigned src[DIM]);
    int unsigned v[DIM];
    int          lim;
    int          n;
    bit          sw;
    bit          done;
    v    = src;
    lim  = DIM - 1;
    n    = 0;
    done = (DIM == 1);
    while (!done) begin
      sw = 1'b0;
      for (int i = 0; i < lim; i++) begin
        n = n + 1;
        if (v[i] > v[i+1]) begin
          int unsigned t;
          t = v[i]; v[i] = v[i+1]; v[i+1] = t;
          sw = 1'b1;
        end
      end
      if (!sw || lim == 1) done = 1'b1;
      else lim = lim - 1;
    end
    return n;
  endfunction

  task automatic model_batch();
    int unsigned v[DIM];
    int unsigned s[DIM];
    for (int i = 0; i < DIM; i++) v[i] = pend[i];
    s = v;
    for (int i = 1; i < DIM; i++) begin
      int unsigned key;
      int          p;
      key = s[i];
      p   = i - 1;
      while (p >= 0 && s[p] > key) begin
        s[p+1] = s[p];
        p = p - 1;
      end
      s[p+1] = key;
    end
    for (int i = 0; i < DIM; i++) exp_q.push_back(s[i]);
    sort_left = bubble_cycles(v);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      exp_q.delete();
      sort_left  = 0;
      collecting = 1'b1;
      stall_prev = 1'b0;
    end else begin
      bit col0;
      bit ov;
      col0 = collecting;
      ov   = !collecting && sort_left == 0 && exp_q.size() > 0;
      check("in_ready", int'(in_ready), int'(col0));
      check("busy", int'(busy), int'(sort_left > 0));
      check("out_valid", int'(out_valid), int'(ov));
      if (stall_prev && ov) check("stall_hold", int'(out_data), held);
      if (busy) busy_seen = busy_seen + 1;
      if (sort_left > 0) sort_left = sort_left - 1;
      if (ov && out_ready) begin
        check("out_data", int'(out_data), int'(exp_q.pop_front()));
        obs_q.push_back(int'(out_data));
        last_out_cyc = cyc;
        if (exp_q.size() == 0) collecting = 1'b1;
      end
      stall_prev = ov && !out_ready;
      held       = int'(out_data);
      if (col0 && in_valid) begin
        pend.push_back(int'(in_data));
        if (pend.size() == 1) first_acc_cyc = cyc;
        if (pend.size() == DIM) begin
          model_batch();
          pend.delete();
          collecting = 1'b0;
        end
      end
    end
  end

  task automatic push_word(input int d, input int gap);
    bit hs;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = WIDTH'(d);
    hs = 1'b0;
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
    end
    if (!hs) check("load_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic load4(input int a, input int b, input int c, input int d, input int gaps);
    push_word(a, gaps ? int'($urandom_range(0, 3)) : 0);
    push_word(b, gaps ? int'($urandom_range(0, 3)) : 0);
    push_word(c, gaps ? int'($urandom_range(0, 3)) : 0);
    push_word(d, gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic drain(input int n, input bit toggle, input bit noise);
    int got;
    bit done;
    got  = 0;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      out_ready = toggle ? (k % 2 == 0) : 1'b1;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = WIDTH'($urandom);
      end
      @(negedge clk);
      if (out_valid && out_ready) got = got + 1;
      if (got == n) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) check("drain_timeout", got, n);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_stream(input string nm, input int a, input int b, input int c, input int d);
    int e[4];
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
    check({nm, "_count"}, obs_q.size() >= 4 ? 4 : obs_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (obs_q.size() > 0) check(nm, obs_q.pop_front(), e[i]);
    end
  endtask

  initial begin
    bit seen;
    #2;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_data", int'(out_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reverse order: worst-case six compare cycles.
    busy_seen = 0;
    load4(4, 3, 2, 1, 0);
    drain(4, 1'b0, 1'b0);
    check("t1_busy_cycles", busy_seen, 6);
    check_stream("t1_stream", 1, 2, 3, 4);

    // Already sorted: one clean pass.
    busy_seen = 0;
    load4(1, 2, 3, 4, 0);
    drain(4, 1'b0, 1'b0);
    check("t2_busy_cycles", busy_seen, 3);
    check_stream("t2_stream", 1, 2, 3, 4);

    // Unsigned extremes and duplicates.
    busy_seen = 0;
    load4(7, 255, 0, 7, 0);
    drain(4, 1'b0, 1'b0);
    check("t3_busy_le6", int'(busy_seen <= 6), 1);
    check_stream("t3_stream", 0, 7, 7, 255);

    // Input gaps, alternating backpressure, stray in_valid during SORT/DRAIN.
    busy_seen = 0;
    load4(5, 200, 5, 0, 1);
    drain(4, 1'b1, 1'b1);
    check_stream("t4_stream", 0, 5, 5, 200);

    // Reset during the second SORT cycle.
    load4(4, 3, 2, 1, 0);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = busy;
    end
    if (!seen) check("t5_busy_timeout", 0, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_out_valid", int'(out_valid), 0);
    check("t5_rst_in_ready", int'(in_ready), 1);
    check("t5_rst_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    obs_q.delete();
    load4(9, 8, 8, 1, 0);
    drain(4, 1'b0, 1'b0);
    check_stream("t5_stream", 1, 8, 8, 9);

    // Back-to-back batches.
    load4(3, 1, 2, 0, 0);
    drain(4, 1'b0, 1'b0);
    load4(200, 100, 150, 50, 0);
    check("t6_next_accept_gap", first_acc_cyc - last_out_cyc, 1);
    drain(4, 1'b0, 1'b0);
    check_stream("t6_stream_a", 0, 1, 2, 3);
    check_stream("t6_stream_b", 50, 100, 150, 200);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
